// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush/forwarding controller for the 5-stage RISC-V pipeline,
//            with a multi-cycle return-redirect FSM. Optional macro
//            HAZARD_PERF_CNT_EN adds StallCnt/FlushCnt performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int RET_BUBBLES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE,
    input  logic             beqE,
    input  logic             ZeroE,
    input  logic             retE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             RetBusy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RET_WAIT = 2'd1,
        S_RET_GO   = 2'd2
    } state_t;

    localparam logic [2:0] C_RET_LOAD = 3'(RET_BUBBLES - 1);

    if (RET_BUBBLES < 1 || RET_BUBBLES > 7 || CNT_W < 1) begin : g_bad_params
        $error("hazard_ctrl: RET_BUBBLES must be 1..7 and CNT_W >= 1");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_lw_stall;
    logic       w_taken;

    assign w_lw_stall = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_taken    = beqE && ZeroE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        PCSrcE      = 1'b0;
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        RetBusy     = 1'b0;

        if (!rst_n) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
        end else begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end

            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end

            case (r_state)
                S_IDLE: begin
                    if (retE) begin
                        StallF    = 1'b1;
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        w_cnt_nxt = C_RET_LOAD;
                        w_state_nxt = (RET_BUBBLES == 1) ? S_RET_GO : S_RET_WAIT;
                    end else if (w_taken) begin
                        PCSrcE = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (w_lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                S_RET_WAIT: begin
                    StallF    = 1'b1;
                    FlushD    = 1'b1;
                    FlushE    = 1'b1;
                    RetBusy   = 1'b1;
                    w_cnt_nxt = r_cnt - 3'd1;
                    // Leave as the counter reaches zero so the PC is held exactly RET_BUBBLES cycles
                    if (r_cnt <= 3'd1) begin
                        w_state_nxt = S_RET_GO;
                    end
                end
                S_RET_GO: begin
                    PCSrcE      = 1'b1;
                    FlushD      = 1'b1;
                    FlushE      = 1'b1;
                    RetBusy     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (StallF) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (FlushE) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl: constant vector table,
//            hand-written return/reset sequences and a randomized run against
//            a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TB_RB    = 2;
    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic [4:0] rs1e;
        logic [4:0] rs2e;
        logic [4:0] rde;
        logic       lde;
        logic       beq;
        logic       zero;
        logic       ret;
        logic [4:0] rdm;
        logic       wm;
        logic [4:0] rdw;
        logic       ww;
    } in_t;

    typedef struct {
        in_t        v;
        logic [9:0] e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    in_t        vin;
    logic       StallF, StallD, FlushD, FlushE, PCSrcE, RetBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [9:0] dut_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [TB_CNT_W-1:0] StallCnt, FlushCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_left   = 0;   // cycles of return sequence still to come (last one is the redirect)
    int m_sc     = 0;
    int m_fc     = 0;
    vec_t tv[15];

    always #5 clk = ~clk;

    assign dut_o = {StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE, RetBusy};

    hazard_ctrl #(.RET_BUBBLES(TB_RB), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(vin.rs1d), .Rs2D(vin.rs2d), .Rs1E(vin.rs1e), .Rs2E(vin.rs2e),
        .RdE(vin.rde), .ResultSrcE(vin.lde), .beqE(vin.beq), .ZeroE(vin.zero),
        .retE(vin.ret), .RdM(vin.rdm), .RegWriteM(vin.wm), .RdW(vin.rdw),
        .RegWriteW(vin.ww),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RetBusy(RetBusy)
`ifdef HAZARD_PERF_CNT_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
    );

    function automatic in_t mk(input logic [4:0] rs1d, input logic [4:0] rs2d,
                               input logic [4:0] rs1e, input logic [4:0] rs2e,
                               input logic [4:0] rde, input logic lde,
                               input logic beq, input logic zero,
                               input logic [4:0] rdm, input logic wm,
                               input logic [4:0] rdw, input logic ww);
        in_t r;
        r = '0;
        r.rs1d = rs1d; r.rs2d = rs2d; r.rs1e = rs1e; r.rs2e = rs2e; r.rde = rde;
        r.lde = lde; r.beq = beq; r.zero = zero;
        r.rdm = rdm; r.wm = wm; r.rdw = rdw; r.ww = ww;
        return r;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs, input in_t v);
        if (v.wm && v.rdm != 0 && v.rdm == rs) return 2'b10;
        if (v.ww && v.rdw != 0 && v.rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [9:0] model_out(input in_t v, input logic rn, input int left);
        logic sf, sd, fd, fe, pc, rb;
        logic [1:0] fa, fb;
        {sf, sd, fd, fe, pc, rb} = '0;
        fa = 2'b00;
        fb = 2'b00;
        if (!rn) begin
            fd = 1'b1; fe = 1'b1;
        end else begin
            fa = fwd(v.rs1e, v);
            fb = fwd(v.rs2e, v);
            if (left > 1) begin
                sf = 1'b1; fd = 1'b1; fe = 1'b1; rb = 1'b1;
            end else if (left == 1) begin
                pc = 1'b1; fd = 1'b1; fe = 1'b1; rb = 1'b1;
            end else if (v.ret) begin
                sf = 1'b1; fd = 1'b1; fe = 1'b1;
            end else if (v.beq && v.zero) begin
                pc = 1'b1; fd = 1'b1; fe = 1'b1;
            end else if (v.lde && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d)) begin
                sf = 1'b1; sd = 1'b1; fe = 1'b1;
            end
        end
        return {sf, sd, fd, fe, pc, fa, fb, rb};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
    task automatic tick(input string nm, input bit use_c, input logic [9:0] c);
        logic [9:0] e;
        e = model_out(vin, rst_n, m_left);
        #2;
        check(nm, 32'(dut_o), 32'(e));
        if (use_c) check({nm, "_const"}, 32'(dut_o), 32'(c));
        if (!rst_n) begin
            m_left = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e[9]) m_sc++;
            if (e[6]) m_fc++;
            if (m_left > 0) m_left--;
            else if (vin.ret) m_left = TB_RB;
        end
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check({nm, "_stallcnt"}, 32'(StallCnt), 32'(TB_CNT_W'(m_sc)));
        check({nm, "_flushcnt"}, 32'(FlushCnt), 32'(TB_CNT_W'(m_fc)));
`endif
    endtask

    initial begin
        tv[0]  = '{mk(0,0,5,0,0,0,0,0,5,1,5,1), 10'b0000010000};
        tv[1]  = '{mk(0,0,5,0,0,0,0,0,5,0,5,1), 10'b0000001000};
        tv[2]  = '{mk(0,0,5,0,0,0,0,0,0,1,0,1), 10'b0000000000};
        tv[3]  = '{mk(0,0,0,0,0,0,0,0,0,1,0,1), 10'b0000000000};
        tv[4]  = '{mk(0,0,0,9,0,0,0,0,9,1,0,0), 10'b0000000100};
        tv[5]  = '{mk(0,0,3,4,0,0,0,0,3,1,4,1), 10'b0000010010};
        tv[6]  = '{mk(0,7,0,0,7,1,0,0,0,0,0,0), 10'b1101000000};
        tv[7]  = '{mk(7,0,0,0,7,1,0,0,0,0,0,0), 10'b1101000000};
        tv[8]  = '{mk(0,0,0,0,0,1,0,0,0,0,0,0), 10'b0000000000};
        tv[9]  = '{mk(7,0,0,0,7,0,0,0,0,0,0,0), 10'b0000000000};
        tv[10] = '{mk(0,0,0,0,0,0,1,1,0,0,0,0), 10'b0011100000};
        tv[11] = '{mk(0,0,0,0,0,0,1,0,0,0,0,0), 10'b0000000000};
        tv[12] = '{mk(0,7,0,0,7,1,1,1,0,0,0,0), 10'b0011100000};
        tv[13] = '{mk(0,7,0,0,7,1,0,1,0,0,0,0), 10'b1101000000};
        tv[14] = '{mk(0,0,6,6,0,0,1,1,6,1,6,1), 10'b0011110100};

        rst_n = 1'b0;
        vin   = '0;
        @(posedge clk);
        #1;

        vin.ret = 1'b1;
        repeat (3) tick("reset_hold", 1, 10'b0011000000);
        rst_n   = 1'b1;
        vin.ret = 1'b0;
        tick("reset_release", 1, 10'b0000000000);

        for (int i = 0; i < 15; i++) begin
            vin = tv[i].v;
            tick($sformatf("vec%0d", i), 1, tv[i].e);
        end

        vin = '0;
        vin.ret = 1'b1;
        tick("ret_n0", 1, 10'b1011000000);
        vin.beq = 1'b1; vin.zero = 1'b1;
        tick("ret_n1", 1, 10'b1011000001);
        vin = '0;
        tick("ret_n2", 1, 10'b0011100001);
        tick("ret_n3", 1, 10'b0000000000);

        vin.ret = 1'b1;
        tick("ret_abort_start", 1, 10'b1011000000);
        vin.ret = 1'b0;
        rst_n   = 1'b0;
        tick("ret_abort_rst", 1, 10'b0011000000);
        rst_n = 1'b1;
        tick("ret_abort_idle", 1, 10'b0000000000);

`ifdef HAZARD_PERF_CNT_EN
        rst_n = 1'b0;
        vin   = '0;
        tick("perf_clr", 0, '0);
        rst_n = 1'b1;
        vin   = mk(0,7,0,0,7,1,0,0,0,0,0,0);
        repeat (17) tick("perf_stall", 0, '0);
        check("perf_stall_wrap", 32'(StallCnt), 32'd1);
        check("perf_flush_wrap", 32'(FlushCnt), 32'd1);
        repeat (3) tick("perf_more", 0, '0);
        rst_n = 1'b0;
        tick("perf_rst", 0, '0);
        check("perf_rst_stall", 32'(StallCnt), 32'd0);
        check("perf_rst_flush", 32'(FlushCnt), 32'd0);
        rst_n = 1'b1;
        vin   = '0;
`endif

        for (int i = 0; i < 3000; i++) begin
            vin.rs1d = 5'($urandom_range(0, 3));
            vin.rs2d = 5'($urandom_range(0, 3));
            vin.rs1e = 5'($urandom_range(0, 3));
            vin.rs2e = 5'($urandom_range(0, 3));
            vin.rde  = 5'($urandom_range(0, 3));
            vin.rdm  = 5'($urandom_range(0, 3));
            vin.rdw  = 5'($urandom_range(0, 3));
            vin.lde  = 1'($urandom_range(0, 1));
            vin.beq  = 1'($urandom_range(0, 1));
            vin.zero = 1'($urandom_range(0, 1));
            vin.wm   = 1'($urandom_range(0, 1));
            vin.ww   = 1'($urandom_range(0, 1));
            vin.ret  = ($urandom_range(0, 11) == 0);
            rst_n    = ($urandom_range(0, 63) != 0);
            tick("rand", 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage RISC-V core.
- Drives the stall and flush inputs of the fetch/decode and decode/execute pipeline registers.
- Consumes the E-stage outputs of the decode/execute register: Rs1E, Rs2E, RdE, ResultSrcE, beqE, retE.
- Produces the ALU operand forwarding selects, and owns a small FSM that sequences multi-cycle return redirects.

Parameters:
RET_BUBBLES, 2, flush cycles inserted after a ret in E before fetch resumes (legal 1..7)
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
Rs1D  input  5  decode-stage source 1
Rs2D  input  5  decode-stage source 2
Rs1E  input  5  execute-stage source 1
Rs2E  input  5  execute-stage source 2
RdE  input  5  execute-stage destination
ResultSrcE  input  1  1 = instruction in E is a load
beqE  input  1  branch instruction in E
ZeroE  input  1  ALU zero flag in E
retE  input  1  ret instruction in E
RdM  input  5  memory-stage destination
RegWriteM  input  1  memory-stage write enable
RdW  input  5  writeback-stage destination
RegWriteW  input  1  writeback-stage write enable
StallF  output  1  hold PC
StallD  output  1  hold F/D register
FlushD  output  1  clear F/D register
FlushE  output  1  clear D/E register (drives its Flush)
PCSrcE  output  1  select branch/return target
ForwardAE  output  2  operand A select
ForwardBE  output  2  operand B select
RetBusy  output  1  high while the return FSM is not IDLE

Behaviour:
Reset
- rst_n is synchronous, active-low; sampled on the rising edge of clk.
- While rst_n=0: StallF=0, StallD=0, FlushD=1, FlushE=1, PCSrcE=0, ForwardAE=ForwardBE=00, RetBusy=0.
- At the first edge with rst_n=0: FSM goes to IDLE, bubble counter to 0.
- Reset mid-redirect aborts the sequence; the FSM is IDLE in the cycle after reset is released.

Forwarding (combinational, same cycle)
- ForwardAE=10 if RegWriteM, RdM!=0 and RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW, RdW!=0 and RdW==Rs1E.
- Else ForwardAE=00.
- M has priority over W.
- ForwardBE follows the same rules using Rs2E.
- x0 is never forwarded.
- Encoding 11 is never driven.

Load-use (combinational)
- lwStall = ResultSrcE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
- lwStall produces StallF=1, StallD=1, FlushE=1 for exactly one cycle.
- The next cycle's load has been bubbled, so the stall self-clears.

Branch
- Taken = beqE & ZeroE.
- Taken produces PCSrcE=1, FlushD=1, FlushE=1 in the same cycle.
- Taken overrides lwStall: StallF=0, StallD=0.

Return FSM: states IDLE, RET_WAIT, RET_GO
- IDLE:
  - On retE=1, load counter with RET_BUBBLES-1 and go to RET_WAIT.
  - In that same cycle: FlushD=1, FlushE=1, StallF=1.
- RET_WAIT:
  - Each cycle: StallF=1, FlushD=1, FlushE=1, RetBusy=1.
  - Counter decrements each cycle.
  - When the counter is 0, go to RET_GO.
- RET_GO (one cycle):
  - PCSrcE=1, FlushD=1, FlushE=1, RetBusy=1, StallF=0.
  - Next state is IDLE.
- With RET_BUBBLES=1, IDLE goes directly to RET_GO.
- While not IDLE:
  - lwStall and branch are ignored, since the E stage holds only bubbles.
  - retE is ignored; no re-trigger.
- Total PC hold = RET_BUBBLES cycles, then one redirect cycle.

Priority when simultaneous (highest first)
- reset
- FSM non-IDLE
- retE in IDLE
- branch taken
- lwStall

Outputs
- All outputs are combinational from inputs and registered state.
- Only the FSM state and counter are registered.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs: StallCnt and FlushCnt, each CNT_W bits.
  - StallCnt increments every cycle StallF=1.
  - FlushCnt increments every cycle FlushE=1.
  - Both wrap modulo 2^CNT_W.
  - Both reset to 0 synchronously with rst_n.
  - Neither counts while rst_n=0.
- When undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with retE=1 -> FlushD=FlushE=1, StallF=0, RetBusy=0; after release with retE=0, FSM IDLE and all flushes 0.
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00; then RegWriteM=0 -> ForwardAE=01; then RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; next cycle, with ResultSrcE=0, all 0.
- Branch overrides load-use: beqE=1, ZeroE=1 together with lwStall conditions -> PCSrcE=1, FlushD=FlushE=1, StallF=StallD=0.
- Return with RET_BUBBLES=2: retE pulse at cycle N -> StallF=1 on N and N+1, PCSrcE=1 on N+2, RetBusy=1 on N+1..N+2, IDLE at N+3; a second retE or beqE at N+1 is ignored.
- HAZARD_PERF_CNT_EN with CNT_W=4: 17 stall cycles -> StallCnt=1 (wrapped); apply rst_n=0 mid-count -> both counters 0 on the next edge.
